// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
// Shares one sequential FP32 multiplier between NUM_REQ client engines.
// A round-robin grant picks a requester, its operands are latched and held
// steady for the multiplier, and the captured product (or a watchdog abort
// result) is handed back to that requester with a valid/ready handshake.
// Only one multiply is ever in flight.

module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           resp_result,
    output logic                  resp_overflow,
    output logic                  resp_error,
    output logic                  mul_start,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_result,
    input  logic                  mul_overflow,
    input  logic                  mul_done,
    output logic                  busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Result returned to a requester whose multiply never completed (quiet NaN)
    localparam logic [31:0] ABORT_RESULT = 32'h7FC0_0000;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt;
    logic [TMR_W-1:0] timer;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    int               cand;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Accept pulse marks the exact cycle the operands are latched; suppressed in reset
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !rst && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Response valid is owned by the granted requester only while in RESP
    always_comb begin
        resp_valid = '0;
        if (state == ST_RESP) begin
            resp_valid[gnt] = 1'b1;
        end
    end

    assign mul_start = (state == ST_ISSUE);

    // Main sequencer: grant, start, wait with watchdog, then hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            gnt           <= '0;
            timer         <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_error    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        gnt   <= grant_idx;
                        mul_a <= req_a[grant_idx*32 +: 32];
                        mul_b <= req_b[grant_idx*32 +: 32];
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        resp_result   <= mul_result;
                        resp_overflow <= mul_overflow;
                        resp_error    <= 1'b0;
                        state         <= ST_RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        resp_result   <= ABORT_RESULT;
                        resp_overflow <= 1'b0;
                        resp_error    <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready[gnt]) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (gnt == IDX_W'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= gnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
